// File: rtl/gelato_wb_arbiter.sv
// gelato_wb_arbiter: round-robin merge of NUM_SRC execution-unit writeback
// channels into the single register-file writeback port, with a one-entry
// registered output stage and valid/ready handshakes on both sides.
// Optional build macro GELATO_WB_ARB_STATS_EN adds per-source grant counters
// (grant_count) and a downstream stall counter (stall_count).
module gelato_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 64,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rdy,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [DATA_WIDTH-1:0]           wb_data,
  output logic [SRC_W-1:0]                wb_src
`ifdef GELATO_WB_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]           grant_count,
  output logic [31:0]                     stall_count
`endif
);

  localparam int unsigned N = NUM_SRC;

  logic                  wb_valid_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [SRC_W-1:0]      wb_src_q;
  logic [SRC_W-1:0]      last_grant_q;

  logic                  load;
  logic                  any_valid;
  logic                  grant;
  logic [SRC_W-1:0]      winner;
  logic [DATA_WIDTH-1:0] win_data;

  assign load      = rdy && (!wb_valid_q || wb_ready);
  assign any_valid = |src_valid;
  assign grant     = rst_n && load && any_valid;

  // Round-robin pick: the modulo scan from last_grant+1 is split into an
  // "above pointer" pass and a wrapped "at or below pointer" pass.
  always_comb begin
    logic             hi_found;
    logic             lo_found;
    logic [SRC_W-1:0] hi_win;
    logic [SRC_W-1:0] lo_win;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (src_valid[i]) begin
        if (SRC_W'(i) > last_grant_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_win   = SRC_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_win   = SRC_W'(i);
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  // Payload mux and one-hot accept for the winning source.
  always_comb begin
    win_data  = '0;
    src_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner == SRC_W'(i)) begin
        win_data     = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        src_ready[i] = grant;
      end
    end
  end

  // Output stage and fairness pointer; pointer moves only on accepted grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_src_q     <= '0;
      last_grant_q <= SRC_W'(N - 1);
    end else if (load) begin
      if (any_valid) begin
        wb_valid_q   <= 1'b1;
        wb_data_q    <= win_data;
        wb_src_q     <= winner;
        last_grant_q <= winner;
      end else begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;

`ifdef GELATO_WB_ARB_STATS_EN
  logic [NUM_SRC*32-1:0] grant_count_q;
  logic [31:0]           stall_count_q;

  // Per-source handshake counters and downstream stall counter (wrapping).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          grant_count_q[i*32 +: 32] <= grant_count_q[i*32 +: 32] + 32'd1;
        end
      end
      if (rdy && wb_valid_q && !wb_ready) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign grant_count = grant_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
